// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: control/status bundle between the sequencer and the RV32I datapath
interface multicycle_control_fsm_if #(parameter int ALU_OP_W = 2);
    logic [6:0]          opcode;
    logic                bcond;
    logic                halt_req;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                pc_source;
    logic                ir_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                pc_to_reg;
    logic                reg_write;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                is_ecall;
    logic                illegal_inst;
    logic                is_halted;
    modport master (
        input  opcode, bcond, halt_req, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, pc_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               is_ecall, illegal_inst, is_halted
    );
    modport slave (
        output opcode, bcond, halt_req, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, pc_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               is_ecall, illegal_inst, is_halted
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: IF/ID/EX/MEM/WB/HALT sequencer for the shared-ALU multi-cycle RV32I core
module multicycle_control_fsm #(parameter int ALU_OP_W = 2) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_control_fsm_if.master      bus
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_SYS = 7'b1110011;
    state_t state, next_state;
    logic is_ld, is_st, is_r, is_i, is_exec;
    assign is_ld   = bus.opcode == OP_LD;
    assign is_st   = bus.opcode == OP_ST;
    assign is_r    = bus.opcode == OP_R;
    assign is_i    = bus.opcode == OP_I;
    assign is_exec = is_r || is_i || is_ld || is_st || bus.opcode == OP_BR ||
                     bus.opcode == OP_JAL || bus.opcode == OP_JALR;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IF;
        else        state <= next_state;
    // Every output defaults to 0, so gating the decode with reset keeps all outputs low during reset.
    always_comb begin
        next_state        = state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.pc_to_reg     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = '0;
        bus.is_ecall      = 1'b0;
        bus.illegal_inst  = 1'b0;
        bus.is_halted     = 1'b0;
        if (reset)
            case (state)
                S_IF: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    next_state    = bus.mem_ready ? S_ID : S_IF;
                end
                S_ID: begin
                    bus.alu_src_a    = 2'b01;
                    bus.alu_src_b    = 2'b10;
                    bus.is_ecall     = bus.opcode == OP_SYS;
                    bus.illegal_inst = !is_exec && bus.opcode != OP_SYS;
                    next_state       = is_exec ? S_EX : (bus.is_ecall && bus.halt_req) ? S_HALT : S_IF;
                end
                S_EX: begin
                    bus.alu_src_a = bus.opcode == OP_JAL ? 2'b00 : 2'b10;
                    bus.alu_src_b = (is_i || is_ld || is_st || bus.opcode == OP_JALR) ? 2'b10 : 2'b00;
                    bus.alu_op    = (is_r || is_i) ? ALU_OP_W'(2) : bus.opcode == OP_BR ? ALU_OP_W'(1) : '0;
                    bus.pc_write_cond = bus.opcode == OP_BR;
                    bus.pc_write  = bus.opcode == OP_JAL || bus.opcode == OP_JALR;
                    bus.pc_source = bus.opcode == OP_BR || bus.opcode == OP_JAL;
                    bus.pc_to_reg = bus.pc_write;
                    bus.reg_write = bus.pc_write;
                    next_state    = (is_r || is_i) ? S_WB : (is_ld || is_st) ? S_MEM : S_IF;
                end
                S_MEM: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = is_ld;
                    bus.mem_write = !is_ld;
                    next_state    = !bus.mem_ready ? S_MEM : is_ld ? S_WB : S_IF;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = is_ld;
                    next_state     = S_IF;
                end
                default: bus.is_halted = 1'b1;
            endcase
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven per-cycle check of the multi-cycle control sequencer
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    multicycle_control_fsm_if #(.ALU_OP_W(2)) bus();
    multicycle_control_fsm #(.ALU_OP_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    // {pw,pwc,ps,ir,iod,mr,mw,m2r,p2r,rw}_srcA_srcB_aluop_{ecall,illegal,halted}
    localparam logic [18:0] ZERO    = 19'b0000000000_00_00_00_000;
    localparam logic [18:0] IF_WAIT = 19'b0000010000_00_01_00_000;
    localparam logic [18:0] IF_GO   = 19'b1001010000_00_01_00_000;
    localparam logic [18:0] ID_OK   = 19'b0000000000_01_10_00_000;
    localparam logic [18:0] ID_ECL  = 19'b0000000000_01_10_00_100;
    localparam logic [18:0] ID_ILL  = 19'b0000000000_01_10_00_010;
    localparam logic [18:0] EX_R    = 19'b0000000000_10_00_10_000;
    localparam logic [18:0] EX_I    = 19'b0000000000_10_10_10_000;
    localparam logic [18:0] EX_LS   = 19'b0000000000_10_10_00_000;
    localparam logic [18:0] EX_BR   = 19'b0110000000_10_00_01_000;
    localparam logic [18:0] EX_JAL  = 19'b1010000011_00_00_00_000;
    localparam logic [18:0] EX_JALR = 19'b1000000011_10_10_00_000;
    localparam logic [18:0] MEM_LD  = 19'b0000110000_00_00_00_000;
    localparam logic [18:0] MEM_ST  = 19'b0000101000_00_00_00_000;
    localparam logic [18:0] WB_LD   = 19'b0000000101_00_00_00_000;
    localparam logic [18:0] WB_ALU  = 19'b0000000001_00_00_00_000;
    localparam logic [18:0] HALTED  = 19'b0000000000_00_00_00_001;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, SYS = 7'b1110011;

    typedef struct { logic [6:0] opc; logic bc; logic hr; logic rdy; logic [18:0] exp; } vec_t;
    vec_t tbl[$];
    int tests = 0, fails = 0;
    logic [18:0] act;
    assign act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write, bus.i_or_d,
                  bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.pc_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.is_ecall, bus.illegal_inst, bus.is_halted};

    task automatic add(input logic [6:0] o, input logic b, input logic h, input logic r, input logic [18:0] e);
        vec_t v;
        v.opc = o; v.bc = b; v.hr = h; v.rdy = r; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] e);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, e);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        bus.opcode = v.opc; bus.bcond = v.bc; bus.halt_req = v.hr; bus.mem_ready = v.rdy;
        @(negedge clk);
        check(name, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode = ST; bus.bcond = 1'b0; bus.halt_req = 1'b0; bus.mem_ready = 1'b1;
        // R-type, ready held, 4 cycles; second pass with ready low outside IF/MEM
        add(R, 0, 0, 1, IF_GO); add(R, 0, 0, 1, ID_OK); add(R, 0, 0, 1, EX_R); add(R, 0, 0, 1, WB_ALU);
        add(R, 0, 0, 1, IF_GO); add(R, 0, 0, 0, ID_OK); add(R, 0, 0, 0, EX_R); add(R, 0, 0, 0, WB_ALU);
        add(I, 0, 0, 1, IF_GO); add(I, 0, 0, 1, ID_OK); add(I, 0, 0, 1, EX_I); add(I, 0, 0, 1, WB_ALU);
        // load with one IF wait and three MEM wait cycles
        add(LD, 0, 0, 0, IF_WAIT); add(LD, 0, 0, 1, IF_GO); add(LD, 0, 0, 1, ID_OK); add(LD, 0, 0, 1, EX_LS);
        add(LD, 0, 0, 0, MEM_LD); add(LD, 0, 0, 0, MEM_LD); add(LD, 0, 0, 0, MEM_LD);
        add(LD, 0, 0, 1, MEM_LD); add(LD, 0, 0, 1, WB_LD);
        add(ST, 0, 0, 1, IF_GO); add(ST, 0, 0, 1, ID_OK); add(ST, 0, 0, 1, EX_LS);
        add(ST, 0, 0, 0, MEM_ST); add(ST, 0, 0, 1, MEM_ST);
        add(BR, 0, 0, 1, IF_GO); add(BR, 0, 0, 1, ID_OK); add(BR, 0, 0, 1, EX_BR);
        add(BR, 1, 0, 1, IF_GO); add(BR, 1, 0, 1, ID_OK); add(BR, 1, 0, 1, EX_BR);
        add(JAL, 0, 0, 1, IF_GO); add(JAL, 0, 0, 1, ID_OK); add(JAL, 0, 0, 1, EX_JAL);
        add(JALR, 0, 0, 1, IF_GO); add(JALR, 0, 0, 1, ID_OK); add(JALR, 0, 0, 1, EX_JALR);
        add(7'h7F, 0, 0, 1, IF_GO); add(7'h7F, 0, 0, 1, ID_ILL);
        add(SYS, 0, 0, 1, IF_GO); add(SYS, 0, 0, 1, ID_ECL);
        add(SYS, 0, 1, 1, IF_GO); add(SYS, 0, 1, 1, ID_ECL);
        add(R, 1, 0, 1, HALTED); add(LD, 0, 0, 0, HALTED); add(7'h7F, 0, 1, 1, HALTED);

        #2;
        check("reset_outputs_zero", ZERO);
        @(posedge clk); #1; reset = 1'b1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset in the middle of a stalled store
        reset = 1'b0; #1;
        check("halt_reset_zero", ZERO);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(tbl[21 + i], $sformatf("st_pre%0d", i));
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("mem_write_held", MEM_ST);
        #1; reset = 1'b0; #1;
        check("mid_mem_reset_zero", ZERO);
        @(posedge clk); #1;
        check("reset_held_over_edge", ZERO);
        reset = 1'b1;
        step(tbl[12], "post_reset_if_wait");
        step(tbl[13], "post_reset_if_go");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
